// File: rtl/bram_stream_reader.sv
// Streams BRAM_DEPTH words out of a BRAM through a 2-entry FIFO with valid/ready backpressure.
// Define BRAM_STREAM_READER_CHECK_EN to build in the Fibonacci sequence checker and its seq_err port.
module bram_stream_reader #(
   parameter int BRAM_DEPTH = 2048,
   parameter int DATA_BITS  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [31:0]          BRAM_addr,
   output logic                 BRAM_clk,
   output logic [DATA_BITS-1:0] BRAM_din,
   input  logic [DATA_BITS-1:0] BRAM_dout,
   output logic                 BRAM_en,
   output logic                 BRAM_rst,
   output logic [3:0]           BRAM_we,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic                 busy
`ifdef BRAM_STREAM_READER_CHECK_EN
   ,
   output logic                 seq_err
`endif
);

   localparam int IW = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BRAM_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state;
   logic [IW-1:0]        index;
   logic                 inflight;
   logic                 inflight_last;
   logic [DATA_BITS-1:0] fifo_data [2];
   logic [1:0]           fifo_last;
   logic                 rd_ptr;
   logic                 wr_ptr;
   logic [1:0]           fifo_count;
   logic                 pop;
   logic                 issue;
   logic [2:0]           occupancy;

   assign BRAM_clk  = clk;
   assign BRAM_rst  = ~rst_n;
   assign BRAM_din  = '0;
   assign BRAM_we   = 4'b0000;
   assign BRAM_addr = 32'(index) << 2;
   assign BRAM_en   = issue;

   assign m_valid = (fifo_count != 2'd0);
   assign m_data  = fifo_data[rd_ptr];
   assign m_last  = fifo_last[rd_ptr] & m_valid;
   assign busy    = (state != IDLE);

   // A read may only be issued if its word is guaranteed a FIFO slot when it returns.
   assign pop       = m_valid & m_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign issue     = (state == RUN) && (occupancy < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         index         <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (index == LAST_IDX);
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  index <= '0;
               end
            end
            RUN: begin
               if (issue) begin
                  if (index == LAST_IDX) state <= DRAIN;
                  else                   index <= index + 1'b1;
               end
            end
            DRAIN: begin
               if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
         fifo_last  <= 2'b00;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_data[wr_ptr] <= BRAM_dout;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

`ifdef BRAM_STREAM_READER_CHECK_EN
   logic [DATA_BITS-1:0] prev1;
   logic [DATA_BITS-1:0] prev2;
   logic [1:0]           seen;

   // seen saturates at 2: the first two words of a pass only seed the recurrence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_err <= 1'b0;
         prev1   <= '0;
         prev2   <= '0;
         seen    <= 2'd0;
      end else if ((state == IDLE) && start) begin
         seq_err <= 1'b0;
         seen    <= 2'd0;
      end else if (pop) begin
         if ((seen == 2'd2) && (m_data != DATA_BITS'(prev1 + prev2))) seq_err <= 1'b1;
         prev2 <= prev1;
         prev1 <= m_data;
         if (seen != 2'd2) seen <= seen + 2'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized self-checking bench for bram_stream_reader: a BRAM array model plus an
// in-order expected-word model covering throughput, backpressure, restart, reset and the optional checker.
module tb_bram_stream_reader;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        m_ready = 1'b0;
   logic [31:0] BRAM_addr;
   logic        BRAM_clk;
   logic [31:0] BRAM_din;
   logic [31:0] BRAM_dout = '0;
   logic        BRAM_en;
   logic        BRAM_rst;
   logic [3:0]  BRAM_we;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        busy;
`ifdef BRAM_STREAM_READER_CHECK_EN
   logic        seq_err;
   bit          expErr = 1'b0;
`endif

   logic [31:0] mem [DEPTH];
   int compared = 0;
   int mismatched = 0;

   bram_stream_reader #(.BRAM_DEPTH(DEPTH), .DATA_BITS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .BRAM_addr (BRAM_addr),
      .BRAM_clk  (BRAM_clk),
      .BRAM_din  (BRAM_din),
      .BRAM_dout (BRAM_dout),
      .BRAM_en   (BRAM_en),
      .BRAM_rst  (BRAM_rst),
      .BRAM_we   (BRAM_we),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy)
`ifdef BRAM_STREAM_READER_CHECK_EN
      ,
      .seq_err   (seq_err)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read BRAM: data appears the cycle after the enable cycle.
   always @(posedge clk) if (BRAM_en) BRAM_dout <= mem[BRAM_addr[12:2]];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic fillFib();
      mem[0] = 32'd0;
      mem[1] = 32'd1;
      for (int i = 2; i < DEPTH; i++) mem[i] = mem[i-1] + mem[i-2];
   endtask

   task automatic fillRandom();
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_m_valid"}, m_valid, 0);
      checkOutput({tag, "_m_data"}, m_data, 0);
      checkOutput({tag, "_m_last"}, m_last, 0);
      checkOutput({tag, "_en"}, BRAM_en, 0);
      checkOutput({tag, "_addr"}, BRAM_addr, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_bram_rst"}, BRAM_rst, 1);
      checkOutput({tag, "_we"}, BRAM_we, 0);
      checkOutput({tag, "_din"}, BRAM_din, 0);
`ifdef BRAM_STREAM_READER_CHECK_EN
      checkOutput({tag, "_seq_err"}, seq_err, 0);
`endif
   endtask

   // Entered and left at posedge+1. Expected stream is mem[0..DEPTH-1] in order.
   task automatic applyStimulus(input int readyPct, input int restartAt, input bit lastStart, input int resetAt);
      int k = 0;
      int issued = 0;
      int cycle = 0;
      int firstXfer = -1;
      int lastXfer = -1;
      int idleBad = 0;
      bit pop = 1'b0;
      bit restartDone = 1'b0;
      bit stalled = 1'b0;
      logic [31:0] stallData = '0;
      logic stallLast = 1'b0;
      logic [31:0] fibSum;
      while (k < DEPTH && cycle < 20000) begin
         m_ready = ($urandom_range(99) < readyPct);
         start = (cycle == 0);
         if (restartAt >= 0 && k == restartAt && !restartDone) begin
            start = 1'b1;
            restartDone = 1'b1;
         end
         if (lastStart && k == DEPTH-1 && m_valid && m_ready) start = 1'b1;
         if (resetAt >= 0 && k == resetAt) begin
            start = 1'b0;
            #2 rst_n = 1'b0;
            #1 checkResetOutputs("midreset");
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
`ifdef BRAM_STREAM_READER_CHECK_EN
            expErr = 1'b0;
`endif
            repeat (10) begin
               @(negedge clk);
               if (m_valid || BRAM_en || busy) idleBad++;
            end
            checkOutput("post_reset_idle", idleBad, 0);
            @(posedge clk);
            #1;
            return;
         end
         @(negedge clk);
         pop = m_valid && m_ready;
         if (cycle == 0) checkOutput("start_cycle_en", BRAM_en, 0);
         if (readyPct == 100 && cycle == 1) checkOutput("lat_en", BRAM_en, 1);
         if (readyPct == 100 && cycle == 2) checkOutput("lat_novalid", m_valid, 0);
         if (readyPct == 100 && cycle == 3) checkOutput("lat_valid", m_valid, 1);
         if (stalled) begin
            checkOutput("hold_valid", m_valid, 1);
            checkOutput("hold_data", m_data, stallData);
            checkOutput("hold_last", m_last, stallLast);
         end
         if (BRAM_en) begin
            checkOutput("credit", ((issued - k - int'(pop)) < 2), 1);
            checkOutput("addr", BRAM_addr, issued * 4);
            issued++;
         end
`ifdef BRAM_STREAM_READER_CHECK_EN
         checkOutput("seq_err", seq_err, expErr);
         if (cycle == 0) expErr = 1'b0;
`endif
         if (pop) begin
            checkOutput("data", m_data, mem[k]);
            checkOutput("last", m_last, (k == DEPTH-1));
            if (firstXfer < 0) firstXfer = cycle;
            lastXfer = cycle;
            fibSum = (k >= 2) ? mem[k-1] + mem[k-2] : 32'd0;
`ifdef BRAM_STREAM_READER_CHECK_EN
            if (k >= 2 && mem[k] != fibSum) expErr = 1'b1;
`endif
            k++;
         end
         stalled = m_valid && !m_ready;
         stallData = m_data;
         stallLast = m_last;
         cycle++;
         @(posedge clk);
         #1 start = 1'b0;
      end
      checkOutput("word_count", k, DEPTH);
      if (readyPct == 100) begin
         checkOutput("first_xfer", firstXfer, 3);
         checkOutput("span", lastXfer - firstXfer, DEPTH - 1);
      end
      @(negedge clk);
      checkOutput("busy_drop", busy, 0);
      repeat (3) begin
         @(negedge clk);
         if (busy || BRAM_en || m_valid) idleBad++;
      end
      checkOutput("idle_after_pass", idleBad, 0);
`ifdef BRAM_STREAM_READER_CHECK_EN
      checkOutput("seq_err_hold", seq_err, expErr);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      fillFib();
      #2 rst_n = 1'b0;
      #10 checkResetOutputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] full throughput pass");
      applyStimulus(100, -1, 1'b0, -1);
      $display("[TB] random contents with 50 percent backpressure");
      fillRandom();
      applyStimulus(50, -1, 1'b0, -1);
      $display("[TB] second start at word 100");
      fillFib();
      applyStimulus(70, 100, 1'b0, -1);
      $display("[TB] start coinciding with final transfer");
      applyStimulus(100, -1, 1'b1, -1);
      $display("[TB] reset at word 500");
      applyStimulus(60, -1, 1'b0, 500);
      $display("[TB] pass after reset");
      applyStimulus(100, -1, 1'b0, -1);
`ifdef BRAM_STREAM_READER_CHECK_EN
      $display("[TB] corrupted word 10");
      mem[10] = 32'hDEADBEEF;
      applyStimulus(100, -1, 1'b0, -1);
      fillFib();
      applyStimulus(100, -1, 1'b0, -1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 2048, meaning the number of 32-bit words read per pass.
REQ-002 SHALL have parameter DATA_BITS, default 32, meaning the word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for the whole block.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a read pass.
REQ-006 SHALL have port BRAM_addr, output, 32 bits: byte address, equal to index<<2.
REQ-007 SHALL have port BRAM_clk, output, 1 bit: equal to clk.
REQ-008 SHALL have port BRAM_din, output, 32 bits: tied to 0.
REQ-009 SHALL have port BRAM_dout, input, 32 bits: read data, valid one cycle after the BRAM_en cycle.
REQ-010 SHALL have port BRAM_en, output, 1 bit: high only in read-issue cycles.
REQ-011 SHALL have port BRAM_rst, output, 1 bit: equal to ~rst_n.
REQ-012 SHALL have port BRAM_we, output, 4 bits: tied to 4'b0000.
REQ-013 SHALL have port m_data, output, 32 bits: output stream word.
REQ-014 SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-015 SHALL have port m_ready, input, 1 bit: consumer accepts the word.
REQ-016 SHALL have port m_last, output, 1 bit: high with the word at index BRAM_DEPTH-1.
REQ-017 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-018 SHALL have port seq_err, output, 1 bit: Fibonacci check failure; exists only when CHECK is built in (REQ-031).

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DRAIN.
- IDLE->RUN on start.
- RUN->DRAIN in the cycle the read for index BRAM_DEPTH-1 is issued.
- DRAIN->IDLE when the FIFO is empty and no read is in flight.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL reset the index to 0 on each accepted start.
- The index increments by 1 per issued read.
- The index is never wrapped within a pass.
- The index holds at BRAM_DEPTH-1 in DRAIN.
REQ-022 SHALL buffer read data in a 2-entry output FIFO.
- A read is issued only when fifo_count + inflight - pop < 2.
- pop = m_valid & m_ready in the same cycle.
REQ-023 SHALL meet this latency with m_ready=1: start high in cycle N -> BRAM_en=1 with BRAM_addr=0 in cycle N+1 -> m_valid=1 with word 0 in cycle N+3.
REQ-024 SHALL sustain one word per cycle after that, giving BRAM_DEPTH words in BRAM_DEPTH consecutive cycles.
REQ-025 SHALL follow these handshake rules:
- m_valid stays high until the transfer completes.
- m_data and m_last are stable while m_valid=1 and m_ready=0.
- No word is dropped or duplicated.
REQ-026 SHALL handle backpressure so that with m_ready=0, at most 2 words are buffered and BRAM_en stays 0 once credits are exhausted.
REQ-027 SHALL handle the end of a pass so that m_last=1 only with the word at index BRAM_DEPTH-1, and busy falls the cycle after that word transfers.
REQ-028 SHALL, for a start that coincides with the final transfer, ignore the start because busy is still 1.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force the following, independent of clk:
- state=IDLE, index=0, FIFO empty, inflight=0;
- m_valid=0, m_data=0, m_last=0;
- BRAM_en=0, BRAM_addr=0;
- busy=0, seq_err=0.
REQ-030 SHALL, on reset asserted mid-pass, abandon the pass; after release the block stays in IDLE until the next start.

Configuration
REQ-031 SHALL build in the checker with macro BRAM_STREAM_READER_CHECK_EN.
- Defined: for every transferred word at index i>=2, assert seq_err when word[i] != (word[i-1]+word[i-2]) mod 2^32, with seq_err registered one cycle after the offending transfer.
- seq_err is sticky until the next accepted start or reset.
- Indices 0 and 1 are never checked.
REQ-032 SHALL, without BRAM_STREAM_READER_CHECK_EN, omit the seq_err port and all checker logic, with no other behaviour change.

Verification
REQ-033 SHALL cover full throughput: BRAM preloaded with Fibonacci 0,1,1,2..., m_ready=1, start -> 2048 words in 2048 consecutive cycles from cycle N+3, m_last only on word 2047, seq_err=0.
REQ-034 SHALL cover backpressure: m_ready random at 50% -> output word sequence identical to the BRAM contents, BRAM_en never issued with 2 words held plus in flight.
REQ-035 SHALL cover start while busy: a second start at word 100 -> ignored, index sequence uninterrupted, exactly 2048 words.
REQ-036 SHALL cover mid-pass reset: rst_n low at word 500 -> all outputs 0 immediately; after release no m_valid until start; the next pass begins at BRAM_addr=0.
REQ-037 SHALL cover the checker (CHECK_EN defined): word 10 corrupted to 0xDEADBEEF -> seq_err=1 one cycle after the word-10 transfer, held until the next start; without the macro, no seq_err port.
